// File: rtl/ptload_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ptload_ctrl
// Purpose  : Page-table loader. Fetches a run of 16-bit PTEs over a req/ack
//            read port and writes them into the paging unit through WE/WPTI/WPTE
//            with one cycle of setup and hold around every WE strobe.
// Options  : define PTLOAD_TIMEOUT_EN to abort a read after TIMEOUT wait cycles
//            and report it on Err; otherwise Err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module ptload_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [19:0] BaseAddr,
    input  logic [5:0]  StartIdx,
    input  logic [6:0]  Count,
    output logic        MemReq,
    output logic [19:0] MemAddr,
    input  logic        MemAck,
    input  logic [15:0] MemData,
    output logic        WE,
    output logic [5:0]  WPTI,
    output logic [15:0] WPTE,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] base_addr, base_addr_nxt;
    logic [5:0]  start_idx, start_idx_nxt;
    logic [6:0]  count_lat, count_lat_nxt;
    logic [6:0]  k, k_nxt;
    logic [6:0]  k_inc;
    logic [6:0]  count_clamped;

    logic        mem_req_nxt;
    logic [19:0] mem_addr_nxt;
    logic        we_nxt;
    logic [5:0]  wpti_nxt;
    logic [15:0] wpte_nxt;
    logic        busy_nxt;
    logic        done_nxt;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_check
        $error("ptload_ctrl: TIMEOUT must lie in 1..255");
    end

`ifdef PTLOAD_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       err_nxt;
`endif

    assign count_clamped = (Count > 7'd64) ? 7'd64 : Count;
    assign k_inc         = k + 7'd1;

    always_comb begin
        state_nxt     = state;
        base_addr_nxt = base_addr;
        start_idx_nxt = start_idx;
        count_lat_nxt = count_lat;
        k_nxt         = k;
        mem_req_nxt   = MemReq;
        mem_addr_nxt  = MemAddr;
        we_nxt        = 1'b0;
        wpti_nxt      = WPTI;
        wpte_nxt      = WPTE;
        busy_nxt      = Busy;
        done_nxt      = 1'b0;
`ifdef PTLOAD_TIMEOUT_EN
        wait_cnt_nxt  = wait_cnt;
        err_nxt       = Err;
`endif
        case (state)
            S_IDLE: begin
                if (Start) begin
                    base_addr_nxt = BaseAddr;
                    start_idx_nxt = StartIdx;
                    count_lat_nxt = count_clamped;
                    k_nxt         = 7'd0;
`ifdef PTLOAD_TIMEOUT_EN
                    err_nxt       = 1'b0;
                    wait_cnt_nxt  = 8'd0;
`endif
                    if (count_clamped == 7'd0) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt    = S_REQ;
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = BaseAddr;
                        busy_nxt     = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // Read data goes straight to WPTE so it is already stable in SETUP.
                if (MemAck) begin
                    mem_req_nxt = 1'b0;
                    wpte_nxt    = MemData;
                    wpti_nxt    = start_idx + k[5:0];
                    state_nxt   = S_SETUP;
                end
`ifdef PTLOAD_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    mem_req_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    state_nxt   = S_DONE;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
`endif
            end
            S_SETUP: begin
                we_nxt    = 1'b1;
                state_nxt = S_STROBE;
            end
            S_STROBE: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                k_nxt = k_inc;
                if (k_inc == count_lat) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    state_nxt    = S_REQ;
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = base_addr + {13'd0, k_inc};
`ifdef PTLOAD_TIMEOUT_EN
                    wait_cnt_nxt = 8'd0;
`endif
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            base_addr <= 20'd0;
            start_idx <= 6'd0;
            count_lat <= 7'd0;
            k         <= 7'd0;
            MemReq    <= 1'b0;
            MemAddr   <= 20'd0;
            WE        <= 1'b0;
            WPTI      <= 6'd0;
            WPTE      <= 16'd0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            base_addr <= base_addr_nxt;
            start_idx <= start_idx_nxt;
            count_lat <= count_lat_nxt;
            k         <= k_nxt;
            MemReq    <= mem_req_nxt;
            MemAddr   <= mem_addr_nxt;
            WE        <= we_nxt;
            WPTI      <= wpti_nxt;
            WPTE      <= wpte_nxt;
            Busy      <= busy_nxt;
            Done      <= done_nxt;
        end
    end

`ifdef PTLOAD_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wait_cnt <= 8'd0;
            Err      <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            Err      <= err_nxt;
        end
    end
`else
    assign Err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ptload_ctrl.sv
`default_nettype none
// Bench for ptload_ctrl: random memory latency and load parameters, checked
// against an arithmetic model of which entries land where and when.
module tb_ptload_ctrl;

    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [5:0]  idx;
        logic [15:0] data;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [19:0] BaseAddr = 20'd0;
    logic [5:0]  StartIdx = 6'd0;
    logic [6:0]  Count = 7'd0;
    logic        MemAck = 1'b0;
    logic [15:0] MemData = 16'd0;
    logic        MemReq, WE, Busy, Done, Err;
    logic [19:0] MemAddr;
    logic [5:0]  WPTI;
    logic [15:0] WPTE;

    always #5 Clk = ~Clk;

    ptload_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr), .StartIdx(StartIdx),
        .Count(Count), .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
        .MemData(MemData), .WE(WE), .WPTI(WPTI), .WPTE(WPTE), .Busy(Busy),
        .Done(Done), .Err(Err)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // memory model controls (written only by the test sequence)
    int          max_delay = 0;
    int          withhold_req = -1;
    logic [15:0] data_xor = 16'h0000;

    // observations (written only by the responder / monitor)
    int          req_num = 0;
    logic [19:0] addr_q[$];
    wr_t         wr_q[$];
    int done_cnt = 0, setup_viol = 0, hold_viol = 0, b2b_viol = 0, addr_viol = 0;
    int busy_viol = 0, req_starts = 0, last_req_len = 0, cur_req_len = 0;
    logic        p_we = 1'b0, p_req = 1'b0, rst_edge = 1'b0;
    logic [5:0]  p_wpti = 6'd0;
    logic [15:0] p_wpte = 16'd0;
    logic [19:0] p_addr = 20'd0;

    function automatic logic [15:0] mem_word(input logic [19:0] a);
        logic [19:0] s;
        s = a + 20'h01000;
        return s[15:0] ^ data_xor;
    endfunction

    function automatic logic [19:0] model_addr(input logic [19:0] base, input int i);
        int unsigned a;
        a = (32'(base) + 32'(i)) % 32'h0010_0000;
        return 20'(a);
    endfunction

    function automatic wr_t model_write(input logic [19:0] base, input logic [5:0] idx,
                                        input int i, input logic [15:0] key);
        wr_t w;
        int unsigned a, x;
        a = (32'(base) + 32'(i)) % 32'h0010_0000;
        x = (32'(idx) + 32'(i)) % 64;
        w.idx  = 6'(x);
        w.data = 16'((a + 32'h1000) % 65536) ^ key;
        return w;
    endfunction

    function automatic int model_entries(input logic [6:0] cnt);
        return (int'(cnt) > 64) ? 64 : int'(cnt);
    endfunction

    // Memory: random ack latency per request; one request can be withheld.
    initial begin : mem_responder
        bit serving;
        int remaining;
        serving = 1'b0;
        remaining = 0;
        forever begin
            @(negedge Clk);
            MemAck  = 1'b0;
            MemData = 16'($urandom);
            if (MemReq !== 1'b1) begin
                serving = 1'b0;
            end else begin
                if (!serving) begin
                    serving = 1'b1;
                    remaining = int'($urandom_range(32'(max_delay), 0));
                    req_num++;
                end
                if (req_num != withhold_req) begin
                    if (remaining == 0) begin
                        MemAck  = 1'b1;
                        MemData = mem_word(MemAddr);
                        addr_q.push_back(MemAddr);
                    end else begin
                        remaining--;
                    end
                end
            end
        end
    end

    always @(posedge Clk) rst_edge <= Rst;

    always @(negedge Clk) begin
        if (WE === 1'b1) begin
            wr_q.push_back({WPTI, WPTE});
            if (p_we === 1'b1) b2b_viol++;
            if (WPTI !== p_wpti || WPTE !== p_wpte) setup_viol++;
        end else if (p_we === 1'b1 && rst_edge !== 1'b1) begin
            if (WPTI !== p_wpti || WPTE !== p_wpte) hold_viol++;
        end
        if (MemReq === 1'b1) begin
            if (p_req === 1'b1) begin
                cur_req_len++;
                if (MemAddr !== p_addr) addr_viol++;
            end else begin
                cur_req_len = 1;
                req_starts++;
            end
        end else if (p_req === 1'b1) begin
            last_req_len = cur_req_len;
        end
        if (Done === 1'b1) begin
            done_cnt++;
            if (Busy !== 1'b0) busy_viol++;
        end
        p_we = WE; p_req = MemReq; p_wpti = WPTI; p_wpte = WPTE; p_addr = MemAddr;
    end

    // Issues one Start and returns at the negedge of the Done cycle (cycle 1 = after Start edge).
    task automatic run_load(input logic [19:0] base, input logic [5:0] idx, input logic [6:0] cnt,
                            input int limit, input bit poke, output int done_cycle,
                            output logic busy1, output logic req1, output logic err1);
        @(negedge Clk);
        BaseAddr = base; StartIdx = idx; Count = cnt; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        BaseAddr = 20'($urandom); StartIdx = 6'($urandom); Count = 7'($urandom);
        busy1 = Busy; req1 = MemReq; err1 = Err;
        done_cycle = -1;
        for (int c = 1; c <= limit; c++) begin
            if (Done === 1'b1) begin
                done_cycle = c;
                break;
            end
            if (poke && c == 20) begin
                Start = 1'b1; Count = 7'd1; BaseAddr = 20'($urandom);
            end
            if (poke && c == 21) Start = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        int dc, w0, r0;
        logic b1, q1, e1;
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        tests_run++;
        if ({MemReq, MemAddr, WE, WPTI, WPTE, Busy, Done, Err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {MemReq, MemAddr, WE, WPTI, WPTE, Busy, Done, Err});
        end
        Rst = 1'b0;
        w0 = wr_q.size(); r0 = req_starts;
        run_load(20'($urandom), 6'($urandom), 7'd0, 20, 1'b0, dc, b1, q1, e1);
        tests_run++;
        if (dc !== 1) begin
            tests_failed++; $display("FAIL count0_done_cycle: got %0d required 1", dc);
        end
        tests_run++;
        if (b1 !== 1'b0 || q1 !== 1'b0) begin
            tests_failed++; $display("FAIL count0_busy_req: got %b%b required 00", b1, q1);
        end
        @(negedge Clk);
        tests_run++;
        if (Done !== 1'b0) begin
            tests_failed++; $display("FAIL count0_done_width: Done=%b required 0", Done);
        end
        tests_run++;
        if (wr_q.size() - w0 != 0 || req_starts - r0 != 0) begin
            tests_failed++;
            $display("FAIL count0_no_activity: writes %0d reqs %0d required 0 0",
                     wr_q.size() - w0, req_starts - r0);
        end
    endtask

    task automatic test_basic();
        int dc, w0, s0, h0, d0, b0;
        logic b1, q1, e1;
        wr_t exp;
        max_delay = 0; data_xor = 16'h0000;
        w0 = wr_q.size(); s0 = setup_viol; h0 = hold_viol; d0 = done_cnt; b0 = b2b_viol;
        run_load(20'h00100, 6'd0, 7'd3, 50, 1'b0, dc, b1, q1, e1);
        tests_run++;
        if (dc !== 13) begin
            tests_failed++; $display("FAIL basic_done_cycle: got %0d required 13", dc);
        end
        tests_run++;
        if (b1 !== 1'b1 || q1 !== 1'b1) begin
            tests_failed++; $display("FAIL basic_busy_req_c1: got %b%b required 11", b1, q1);
        end
        @(negedge Clk);
        tests_run++;
        if (wr_q.size() - w0 != 3) begin
            tests_failed++; $display("FAIL basic_write_count: got %0d required 3", wr_q.size() - w0);
        end
        for (int i = 0; i < 3 && w0 + i < wr_q.size(); i++) begin
            exp = model_write(20'h00100, 6'd0, i, 16'h0000);
            tests_run++;
            if (wr_q[w0 + i] !== exp) begin
                tests_failed++;
                $display("FAIL basic_entry%0d: got %0h required %0h", i, wr_q[w0 + i], exp);
            end
        end
        tests_run++;
        if (setup_viol - s0 != 0 || hold_viol - h0 != 0 || b2b_viol - b0 != 0) begin
            tests_failed++;
            $display("FAIL basic_setup_hold: setup %0d hold %0d b2b %0d required 0 0 0",
                     setup_viol - s0, hold_viol - h0, b2b_viol - b0);
        end
        tests_run++;
        if (done_cnt - d0 != 1 || busy_viol != 0 || Err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_err: dones %0d busyviol %0d err %b required 1 0 0",
                     done_cnt - d0, busy_viol, Err);
        end
    endtask

    task automatic test_wrap();
        int dc, w0, a0;
        logic b1, q1, e1;
        wr_t exp;
        max_delay = 0; data_xor = 16'h0000;
        w0 = wr_q.size(); a0 = addr_q.size();
        run_load(20'hFFFFE, 6'd62, 7'd4, 50, 1'b0, dc, b1, q1, e1);
        @(negedge Clk);
        tests_run++;
        if (dc !== 17 || wr_q.size() - w0 != 4) begin
            tests_failed++;
            $display("FAIL wrap_cycle_count: done %0d writes %0d required 17 4", dc, wr_q.size() - w0);
        end
        for (int i = 0; i < 4 && w0 + i < wr_q.size() && a0 + i < addr_q.size(); i++) begin
            exp = model_write(20'hFFFFE, 6'd62, i, 16'h0000);
            tests_run++;
            if (wr_q[w0 + i] !== exp || addr_q[a0 + i] !== model_addr(20'hFFFFE, i)) begin
                tests_failed++;
                $display("FAIL wrap_entry%0d: got %0h @%0h required %0h @%0h", i, wr_q[w0 + i],
                         addr_q[a0 + i], exp, model_addr(20'hFFFFE, i));
            end
        end
    endtask

    task automatic test_random_loads();
        logic [6:0]  cnts [5];
        logic [19:0] base;
        logic [5:0]  idx;
        int dc, w0, n, bad;
        logic b1, q1, e1;
        cnts = '{7'd1, 7'd64, 7'd65, 7'd127, 7'($urandom_range(63, 2))};
        max_delay = 0;
        foreach (cnts[j]) begin
            base = 20'($urandom); idx = 6'($urandom); data_xor = 16'($urandom);
            n = model_entries(cnts[j]);
            w0 = wr_q.size();
            run_load(base, idx, cnts[j], 400, 1'b0, dc, b1, q1, e1);
            @(negedge Clk);
            tests_run++;
            if (dc !== 4 * n + 1 || wr_q.size() - w0 != n) begin
                tests_failed++;
                $display("FAIL rand_load_count%0d: done %0d writes %0d required %0d %0d",
                         cnts[j], dc, wr_q.size() - w0, 4 * n + 1, n);
            end
            bad = 0;
            for (int i = 0; i < n && w0 + i < wr_q.size(); i++)
                if (wr_q[w0 + i] !== model_write(base, idx, i, data_xor)) bad++;
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL rand_load_entries%0d: %0d wrong entries required 0", cnts[j], bad);
            end
        end
    endtask

    task automatic test_clamp_waits();
        logic [19:0] base;
        logic [5:0]  idx;
        int dc, w0, a0, d0, av0, s0, h0, bad_w, bad_a;
        logic b1, q1, e1;
        max_delay = 5; data_xor = 16'($urandom);
        base = 20'hFFFE0 + 20'($urandom_range(31, 0)); idx = 6'($urandom);
        w0 = wr_q.size(); a0 = addr_q.size(); d0 = done_cnt; av0 = addr_viol;
        s0 = setup_viol; h0 = hold_viol;
        run_load(base, idx, 7'd100, 1500, 1'b1, dc, b1, q1, e1);
        @(negedge Clk);
        max_delay = 0;
        tests_run++;
        if (dc < 1 || wr_q.size() - w0 != 64 || done_cnt - d0 != 1) begin
            tests_failed++;
            $display("FAIL clamp_done_writes: done %0d writes %0d dones %0d required >0 64 1",
                     dc, wr_q.size() - w0, done_cnt - d0);
        end
        bad_w = 0; bad_a = 0;
        for (int i = 0; i < 64 && w0 + i < wr_q.size() && a0 + i < addr_q.size(); i++) begin
            if (wr_q[w0 + i] !== model_write(base, idx, i, data_xor)) bad_w++;
            if (addr_q[a0 + i] !== model_addr(base, i)) bad_a++;
        end
        tests_run++;
        if (bad_w != 0 || bad_a != 0) begin
            tests_failed++;
            $display("FAIL clamp_entries: wrong data %0d wrong addr %0d required 0 0", bad_w, bad_a);
        end
        tests_run++;
        if (addr_viol - av0 != 0 || setup_viol - s0 != 0 || hold_viol - h0 != 0) begin
            tests_failed++;
            $display("FAIL clamp_stability: addr %0d setup %0d hold %0d required 0 0 0",
                     addr_viol - av0, setup_viol - s0, hold_viol - h0);
        end
    endtask

    task automatic test_reset_midload();
        logic [19:0] base;
        int strobes, dc, w0, d0, seen;
        bit hit;
        logic b1, q1, e1;
        max_delay = 0; data_xor = 16'h0000;
        base = 20'($urandom);
        w0 = wr_q.size(); d0 = done_cnt;
        @(negedge Clk);
        BaseAddr = base; StartIdx = 6'd10; Count = 7'd5; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        strobes = 0; hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (WE === 1'b1) strobes++;
            if (strobes == 3) begin
                hit = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        tests_run++;
        if (!hit) begin
            tests_failed++; $display("FAIL rstmid_reach_strobe: strobes %0d required 3", strobes);
        end
        Rst = 1'b1;
        @(negedge Clk);
        tests_run++;
        if ({WE, MemReq, Busy, Done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: WE/MemReq/Busy/Done %b required 0000", {WE, MemReq, Busy, Done});
        end
        Rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Done === 1'b1 || WE === 1'b1 || MemReq === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0 || done_cnt - d0 != 0 || wr_q.size() - w0 != 3) begin
            tests_failed++;
            $display("FAIL rstmid_quiet: activity %0d dones %0d writes %0d required 0 0 3",
                     seen, done_cnt - d0, wr_q.size() - w0);
        end
        w0 = wr_q.size();
        run_load(base, 6'd40, 7'd2, 50, 1'b0, dc, b1, q1, e1);
        @(negedge Clk);
        tests_run++;
        if (dc !== 9 || wr_q.size() - w0 != 2 || wr_q[w0 + 1] !== model_write(base, 6'd40, 1, 16'h0000)) begin
            tests_failed++;
            $display("FAIL rstmid_reload: done %0d writes %0d required 9 2", dc, wr_q.size() - w0);
        end
    endtask

`ifdef PTLOAD_TIMEOUT_EN
    task automatic test_timeout();
        int dc, w0;
        logic b1, q1, e1;
        logic err_at_done;
        max_delay = 0; data_xor = 16'h0000;
        w0 = wr_q.size();
        withhold_req = req_num + 2;
        run_load(20'h00200, 6'd5, 7'd3, 60, 1'b0, dc, b1, q1, e1);
        err_at_done = Err;
        @(negedge Clk);
        withhold_req = -1;
        tests_run++;
        if (dc !== 13 || err_at_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_done_err: done %0d err %b required 13 1", dc, err_at_done);
        end
        tests_run++;
        if (last_req_len != TIMEOUT || wr_q.size() - w0 != 1) begin
            tests_failed++;
            $display("FAIL timeout_req_len_writes: req %0d writes %0d required %0d 1",
                     last_req_len, wr_q.size() - w0, TIMEOUT);
        end
        tests_run++;
        if (Err !== 1'b1) begin
            tests_failed++; $display("FAIL timeout_err_sticky: got %b required 1", Err);
        end
        run_load(20'h00300, 6'd0, 7'd1, 20, 1'b0, dc, b1, q1, e1);
        tests_run++;
        if (e1 !== 1'b0 || dc !== 5) begin
            tests_failed++;
            $display("FAIL timeout_err_clear: err %b done %0d required 0 5", e1, dc);
        end
        @(negedge Clk);
    endtask
`endif

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random_loads();
        test_clamp_waits();
        test_reset_midload();
`ifdef PTLOAD_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
